// File: rtl/ysyx_25020047_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package ysyx_25020047_mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Owner encoding used by grant_ls and the picker.
  localparam logic GRANT_IFU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ysyx_25020047_arb_pick.sv
// Combinational winner selection between IFU and LSU.
// Macro YSYX_25020047_ARB_RR_EN: round-robin with a last-winner flop;
// otherwise fixed LSU priority and no state at all.
module ysyx_25020047_arb_pick
  import ysyx_25020047_mem_arbiter_pkg::*;
(
`ifdef YSYX_25020047_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic accept,
`endif
  input  logic if_valid,
  input  logic ls_valid,
  output logic pick_ls,
  output logic any_valid
);

  assign any_valid = if_valid | ls_valid;

`ifdef YSYX_25020047_ARB_RR_EN
  logic r_last_ls;

  // On contention the side that lost last time wins; otherwise whoever is valid.
  always_comb begin
    pick_ls = ls_valid ? GRANT_LSU : GRANT_IFU;
    if (if_valid && ls_valid)
      pick_ls = ~r_last_ls;
  end

  // Remember the winner of every accepted request; reset favours IFU next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_last_ls <= GRANT_LSU;
    else if (accept)
      r_last_ls <= pick_ls;
  end
`else
  // Fixed priority: LSU always beats IFU.
  always_comb begin
    pick_ls = ls_valid ? GRANT_LSU : GRANT_IFU;
  end
`endif

endmodule

// File: rtl/ysyx_25020047_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to single-memory arbiter.
// One transaction outstanding: IDLE (accept) -> ISSUE (hold request) -> WAIT (response).
// Macro YSYX_25020047_ARB_RR_EN selects round-robin arbitration (see arb_pick).
module ysyx_25020047_mem_arbiter
  import ysyx_25020047_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  // IFU
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  // LSU
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  // memory
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  // trace
  output logic                grant_ls
);

  arb_state_e          r_state, w_state_nxt;
  logic                r_grant_ls;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wmask;

  logic w_pick_ls, w_any, w_accept;

  // Ready must stay low while reset is asserted even if a requester is valid.
  assign w_accept = (r_state == ST_IDLE) && w_any && !rst;

  ysyx_25020047_arb_pick u_pick (
`ifdef YSYX_25020047_ARB_RR_EN
    .clk       (clk),
    .rst       (rst),
    .accept    (w_accept),
`endif
    .if_valid  (if_req_valid),
    .ls_valid  (ls_req_valid),
    .pick_ls   (w_pick_ls),
    .any_valid (w_any)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus all handshake/response outputs.
  always_comb begin
    w_state_nxt   = r_state;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    if_rdata      = '0;
    ls_rdata      = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if_req_ready = (w_pick_ls == GRANT_IFU);
          ls_req_ready = (w_pick_ls == GRANT_LSU);
          w_state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Response is forwarded in the same cycle; no new accept until IDLE.
        if (mem_resp_valid) begin
          if (r_grant_ls == GRANT_LSU) begin
            ls_resp_valid = 1'b1;
            ls_rdata      = mem_rdata;
          end else begin
            if_resp_valid = 1'b1;
            if_rdata      = mem_rdata;
          end
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winner's request fields on accept; IFU requests are always reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_ls <= GRANT_IFU;
      r_addr     <= '0;
      r_wen      <= 1'b0;
      r_wdata    <= '0;
      r_wmask    <= '0;
    end else if (w_accept) begin
      r_grant_ls <= w_pick_ls;
      if (w_pick_ls == GRANT_LSU) begin
        r_addr  <= ls_addr;
        r_wen   <= ls_wen;
        r_wdata <= ls_wdata;
        r_wmask <= ls_wmask;
      end else begin
        r_addr  <= if_addr;
        r_wen   <= 1'b0;
        r_wdata <= '0;
        r_wmask <= '0;
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wen   = r_wen;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;
  assign grant_ls  = r_grant_ls;

endmodule

// File: tb/tb_ysyx_25020047_mem_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_ysyx_25020047_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req_valid = 1'b0, if_req_ready;
  logic [AW-1:0] if_addr = '0;
  logic          if_resp_valid;
  logic [DW-1:0] if_rdata;
  logic          ls_req_valid = 1'b0, ls_req_ready;
  logic [AW-1:0] ls_addr = '0;
  logic          ls_wen = 1'b0;
  logic [DW-1:0] ls_wdata = '0;
  logic [3:0]    ls_wmask = '0;
  logic          ls_resp_valid;
  logic [DW-1:0] ls_rdata;
  logic          mem_req_valid, mem_req_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          grant_ls;

  ysyx_25020047_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .grant_ls(grant_ls)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction is either absent, waiting for memory to take it, or
  // waiting for memory's answer. Only that fact plus the captured request
  // is tracked.
  typedef struct {
    bit            ls;
    logic [AW-1:0] addr;
    bit            wen;
    logic [DW-1:0] wdata;
    logic [3:0]    wmask;
  } txn_t;

  bit   m_have_txn = 0;   // a request has been accepted and not answered
  bit   m_mem_took = 0;   // memory has taken the request
  txn_t m_txn;
  bit   m_owner = 0;      // last granted side, visible on grant_ls
  bit   m_last_ls = 1;    // round-robin history
  bit   acc_if = 0, acc_ls = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst if_req_ready", if_req_ready, 0);
      chk("rst ls_req_ready", ls_req_ready, 0);
      chk("rst if_resp_valid", if_resp_valid, 0);
      chk("rst ls_resp_valid", ls_resp_valid, 0);
      chk("rst if_rdata", if_rdata, 0);
      chk("rst ls_rdata", ls_rdata, 0);
      chk("rst mem_req_valid", mem_req_valid, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_wen", mem_wen, 0);
      chk("rst mem_wmask", mem_wmask, 0);
      chk("rst grant_ls", grant_ls, 0);
      m_have_txn = 0; m_mem_took = 0; m_owner = 0; m_last_ls = 1;
      acc_if = 0; acc_ls = 0;
    end else begin
      bit any, win_ls, resp;
      any = if_req_valid || ls_req_valid;
`ifdef YSYX_25020047_ARB_RR_EN
      win_ls = (if_req_valid && ls_req_valid) ? !m_last_ls : ls_req_valid;
`else
      win_ls = ls_req_valid;
`endif
      acc_if = !m_have_txn && any && !win_ls;
      acc_ls = !m_have_txn && any && win_ls;
      resp   = m_have_txn && m_mem_took && mem_resp_valid;

      chk("if_req_ready", if_req_ready, acc_if);
      chk("ls_req_ready", ls_req_ready, acc_ls);
      chk("mem_req_valid", mem_req_valid, m_have_txn && !m_mem_took);
      chk("grant_ls", grant_ls, m_owner);
      chk("if_resp_valid", if_resp_valid, resp && !m_txn.ls);
      chk("ls_resp_valid", ls_resp_valid, resp && m_txn.ls);
      chk("if_rdata", if_rdata, (resp && !m_txn.ls) ? mem_rdata : 0);
      chk("ls_rdata", ls_rdata, (resp && m_txn.ls) ? mem_rdata : 0);
      if (m_have_txn && !m_mem_took) begin
        chk("mem_addr", mem_addr, m_txn.addr);
        chk("mem_wen", mem_wen, m_txn.wen);
        chk("mem_wmask", mem_wmask, m_txn.wmask);
        if (m_txn.wen) chk("mem_wdata", mem_wdata, m_txn.wdata);
      end

      // advance to what the next clock edge produces
      if (acc_if || acc_ls) begin
        m_have_txn = 1; m_mem_took = 0;
        m_txn.ls    = acc_ls;
        m_txn.addr  = acc_ls ? ls_addr : if_addr;
        m_txn.wen   = acc_ls ? ls_wen : 0;
        m_txn.wdata = ls_wdata;
        m_txn.wmask = acc_ls ? ls_wmask : 4'h0;
        m_owner   = acc_ls;
        m_last_ls = acc_ls;
      end else if (m_have_txn && !m_mem_took && mem_req_ready) begin
        m_mem_took = 1;
      end else if (resp) begin
        m_have_txn = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic to_drive(); @(posedge clk); #1; endtask
  task automatic to_check(); @(negedge clk); endtask

  task automatic do_reset();
    to_drive();
    rst = 1'b1;
    if_req_valid = 1'b1; ls_req_valid = 1'b1;   // ready must still stay low
    mem_resp_valid = 1'b1;
    to_check();
    to_drive();
    to_check();
    to_drive();
    rst = 1'b0;
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
  endtask

  initial begin
    int wins[$];
    int hs, lresp;
    logic [3:0] exp_w [4];

    do_reset();

    // IFU fetch, memory ready immediately, answer one cycle later
    if_req_valid = 1; if_addr = 32'h8000_0000; mem_req_ready = 1;
    to_check(); chk("t1 accept", if_req_ready, 1);
    to_drive(); if_req_valid = 0;
    to_check();
    chk("t1 issue", mem_req_valid, 1);
    chk("t1 addr", mem_addr, 32'h8000_0000);
    chk("t1 wen", mem_wen, 0);
    to_drive(); mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
    to_check();
    chk("t1 resp cycle3", if_resp_valid, 1);
    chk("t1 rdata", if_rdata, 32'h0000_0413);
    to_drive(); mem_resp_valid = 0;
    to_check(); chk("t1 resp done", if_resp_valid, 0);

    // LSU store held off by memory for four cycles
    to_drive();
    mem_req_ready = 0;
    ls_req_valid = 1; ls_addr = 32'h8000_1000; ls_wen = 1;
    ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'hF;
    to_check(); chk("t2 accept", ls_req_ready, 1);
    to_drive(); ls_req_valid = 0;
    hs = 0; lresp = 0;
    for (int i = 0; i < 4; i++) begin
      to_check();
      chk("t2 stall valid", mem_req_valid, 1);
      chk("t2 stall addr", mem_addr, 32'h8000_1000);
      chk("t2 stall wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("t2 stall wmask", mem_wmask, 4'hF);
      chk("t2 stall wen", mem_wen, 1);
      if (i < 3) to_drive();
    end
    to_drive(); mem_req_ready = 1;
    for (int i = 0; i < 5; i++) begin
      to_check();
      if (mem_req_valid && mem_req_ready) hs++;
      if (ls_resp_valid) lresp++;
      to_drive();
      mem_req_ready = 0;
      mem_resp_valid = (i == 0);
      mem_rdata = 32'h1111_2222;
    end
    mem_resp_valid = 0;
    chk("t2 one write", hs, 1);
    chk("t2 one response", lresp, 1);

    // both requesters permanently valid
    do_reset();
    if_req_valid = 1; if_addr = 32'h8000_0040;
    ls_req_valid = 1; ls_addr = 32'h8000_2000; ls_wen = 0; ls_wmask = 0;
    mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'hCAFE_0001;
    for (int i = 0; i < 12; i++) begin
      to_check();
      if (if_req_ready || ls_req_ready) wins.push_back(int'(ls_req_ready));
      to_drive();
    end
`ifdef YSYX_25020047_ARB_RR_EN
    exp_w = '{4'd0, 4'd1, 4'd0, 4'd1};
`else
    exp_w = '{4'd1, 4'd1, 4'd1, 4'd1};
`endif
    chk("t3 grant count", wins.size(), 4);
    for (int i = 0; i < 4 && i < wins.size(); i++) chk("t3 winner", wins[i], exp_w[i]);
    if_req_valid = 0; ls_req_valid = 0; mem_resp_valid = 0;

    // reset while waiting for the answer, then a late answer
    do_reset();
    if_req_valid = 1; if_addr = 32'h8000_0080; mem_req_ready = 1;
    to_check(); chk("t4 accept", if_req_ready, 1);
    to_drive(); if_req_valid = 0;
    to_check();
    to_drive(); rst = 1;
    to_check(); chk("t4 in reset resp", if_resp_valid, 0);
    to_drive(); rst = 0; mem_resp_valid = 1; mem_rdata = 32'h5555_AAAA;
    to_check();
    chk("t4 late resp if", if_resp_valid, 0);
    chk("t4 late resp ls", ls_resp_valid, 0);
    chk("t4 idle no req", mem_req_valid, 0);
    to_drive(); mem_resp_valid = 0; if_req_valid = 1; if_addr = 32'h8000_0084;
    to_check(); chk("t4 new accept", if_req_ready, 1);
    to_drive(); if_req_valid = 0;
    to_check(); chk("t4 new addr", mem_addr, 32'h8000_0084);
    to_drive(); mem_resp_valid = 1; mem_rdata = 32'h0000_0013;
    to_check(); chk("t4 new resp", if_rdata, 32'h0000_0013);
    to_drive(); mem_resp_valid = 0;

    // stray memory response while idle
    to_drive(); mem_resp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
    to_check();
    chk("t5 stray if", if_resp_valid, 0);
    chk("t5 stray ls", ls_resp_valid, 0);
    chk("t5 stray rdata", if_rdata, 0);
    to_drive(); mem_resp_valid = 0; ls_req_valid = 1; ls_wen = 1; ls_addr = 32'h8000_3000;
    to_check(); chk("t5 still idle", ls_req_ready, 1);
    to_drive(); ls_req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      to_drive(); mem_resp_valid = 1;
    end
    mem_resp_valid = 0;

    // randomized traffic, model checks every cycle
    for (int i = 0; i < 4000; i++) begin
      to_drive();
      if (rst) rst = 0;
      if (acc_if) if_req_valid = 0;
      if (acc_ls) ls_req_valid = 0;
      if (!if_req_valid && $urandom_range(2) == 0) begin
        if_req_valid = 1; if_addr = $urandom;
      end
      if (!ls_req_valid && $urandom_range(2) == 0) begin
        ls_req_valid = 1; ls_addr = $urandom; ls_wen = $urandom_range(1);
        ls_wdata = $urandom; ls_wmask = 4'($urandom);
      end
      mem_req_ready  = ($urandom_range(2) != 0);
      mem_resp_valid = $urandom_range(1) == 1;
      mem_rdata      = $urandom;
      if ($urandom_range(399) == 0) rst = 1;
    end
    to_drive(); rst = 0;
    to_check();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_25020047_mem_arbiter.md
YSYX_25020047_MEM_ARBITER -- requirements
Module: ysyx_25020047_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width; DATA_W/8 mask bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have IFU ports if_req_valid in 1, if_req_ready out 1, if_addr in ADDR_W, if_resp_valid out 1, if_rdata out DATA_W; the IFU side is read-only.
REQ-006 SHALL have LSU ports ls_req_valid in 1, ls_req_ready out 1, ls_addr in ADDR_W, ls_wen in 1, ls_wdata in DATA_W, ls_wmask in DATA_W/8, ls_resp_valid out 1, ls_rdata out DATA_W.
REQ-007 SHALL have memory ports mem_req_valid out 1, mem_req_ready in 1, mem_addr out ADDR_W, mem_wen out 1, mem_wdata out DATA_W, mem_wmask out DATA_W/8, mem_resp_valid in 1, mem_rdata in DATA_W.
REQ-008 SHALL have port grant_ls  output  1  current owner: 1 = LSU, 0 = IFU (debug/trace).

Function
REQ-009 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE, with exactly one memory transaction outstanding.
REQ-010 IDLE: if any requester is valid, SHALL pick the winner, latch its addr/wen/wdata/wmask and grant, pulse that requester's *_req_ready for that cycle, and go to ISSUE; otherwise stay.
REQ-011 IFU latched request SHALL force wen=0 and wmask=0.
REQ-012 ISSUE: SHALL hold mem_req_valid=1 with the latched fields stable until mem_req_ready=1, then go to WAIT.
REQ-013 WAIT: on mem_resp_valid=1, SHALL drive the granted side's *_resp_valid=1 and *_rdata=mem_rdata combinationally in that cycle, then return to IDLE.
REQ-014 Requesters SHALL always accept responses; there is no response backpressure.
REQ-015 The non-granted *_resp_valid SHALL be 0; each *_rdata SHALL be 0 whenever its *_resp_valid is 0.
REQ-016 *_req_ready SHALL be 0 outside the IDLE accept cycle; a requester held valid waits with no loss.
REQ-017 A new request SHALL NOT be accepted in the same cycle a response completes; minimum round trip is 3 cycles (accept, issue with ready, response).
REQ-018 mem_resp_valid outside WAIT SHALL be ignored.
REQ-019 Arbitration (arbitration SHALL be fixed-priority unless ARB_RR_EN is defined, REQ-024): LSU wins over IFU when both are valid in IDLE.

Reset
REQ-020 On rst=1, SHALL asynchronously go to IDLE with grant_ls=0, latched fields=0, and every valid/ready output and rdata output = 0.
REQ-021 Reset in ISSUE or WAIT SHALL abandon the transaction with no response to either requester; a late mem_resp_valid is ignored per REQ-018.
REQ-022 The round-robin last-winner flag SHALL reset to "LSU last", so IFU wins the first contested arbitration.

Configuration
REQ-023 Macro YSYX_25020047_ARB_RR_EN SHALL select the arbitration policy.
REQ-024 Defined: round-robin; on contention the side that did not win the previous granted transaction wins, and the last-winner flag updates on every accept. Undefined: fixed LSU priority per REQ-019, with no last-winner flop.

Structure
REQ-025 A shared package SHALL hold the FSM state enum (IDLE/ISSUE/WAIT), the grant encoding constants, and the default width constants.
REQ-026 One sub-module, ysyx_25020047_arb_pick, SHALL contain the combinational winner selection, including the RR flag logic under the macro.
REQ-027 The datapath latch and FSM SHALL live in the top arbiter.

Verification
REQ-028 IFU only, if_addr=0x80000000, mem_req_ready=1, resp after 1 cycle with 0x00000413 -> if_resp_valid in cycle 3, if_rdata=0x00000413, mem_wen=0.
REQ-029 LSU store ls_addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF, mem_req_ready held 0 for 4 cycles -> mem fields stable across the stall, one write issued, ls_resp_valid once.
REQ-030 Both valid every cycle, fixed build -> LSU granted in every transaction and IFU starves; RR build -> grants alternate IFU, LSU, IFU, LSU...
REQ-031 rst asserted in WAIT, then mem_resp_valid=1 after rst releases -> no *_resp_valid, state IDLE, next IFU request serviced normally.
REQ-032 mem_resp_valid pulsed while IDLE -> no response outputs asserted, no state change.
